// File: rtl/cpu_mailbox_ctrl.sv
// cpu_mailbox_ctrl
//   Host-side controller for the RISC-V CPU's memory-mapped mailbox.
//   The CPU is held in reset while the argument words and cleared NODE/DONE
//   words are written through the external write port. The CPU is then
//   released and its stores are snooped. NODE writes feed a path FIFO for
//   the navigator. A DONE write of 1, or the run timer expiring, ends the run.
// Ports
//   clk, reset_n                  clock, async active-low reset
//   start, abort                  run control (abort has highest priority)
//   args_in                       NUM_ARGS packed argument words, arg0 in the LSBs
//   cpu_reset                     CPU reset, active-high
//   ext_we/ext_addr/ext_wdata     mailbox write port into the CPU memory
//   cpu_we/cpu_addr/cpu_wdata     snooped CPU store bus
//   path_rd/path_data/path_empty/path_count/path_ovf   path FIFO (FWFT)
//   last_node                     most recent NODE value stored by the CPU
//   busy, done, timeout           status (done/timeout are sticky until start)
module cpu_mailbox_ctrl #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          NUM_ARGS    = 2,
  parameter int          PATH_DEPTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_ARGS*DATA_W-1:0]   args_in,
  output logic                         cpu_reset,
  output logic                         ext_we,
  output logic [31:0]                  ext_addr,
  output logic [DATA_W-1:0]            ext_wdata,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         path_rd,
  output logic [DATA_W-1:0]            path_data,
  output logic                         path_empty,
  output logic [$clog2(PATH_DEPTH):0]  path_count,
  output logic                         path_ovf,
  output logic [DATA_W-1:0]            last_node,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout
);

  localparam int          AW        = $clog2(PATH_DEPTH);
  localparam int          CW        = AW + 1;
  localparam int          IW        = $clog2(NUM_ARGS + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ARGS + 1);
  localparam logic [31:0] NODE_ADDR = BASE_ADDR + 32'(4 * NUM_ARGS);
  localparam logic [31:0] DONE_ADDR = NODE_ADDR + 32'd4;
  localparam logic [31:0] TO_LAST   = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

  state_t                    r_state;
  logic [IW-1:0]             r_idx;
  logic [31:0]               r_timer;
  logic [NUM_ARGS*DATA_W-1:0] r_args;
  logic [DATA_W-1:0]         r_mem [PATH_DEPTH];
  logic [AW-1:0]             r_wp, r_rp;
  logic [CW-1:0]             r_count;

  logic w_run, w_start, w_node_wr, w_done_wr, w_tmo, w_full, w_pop, w_push;

  // Load-sequence word for slot idx: args first, then the zeroed NODE/DONE words.
  function automatic logic [DATA_W-1:0] f_wdata(input logic [IW-1:0] idx,
                                                 input logic [NUM_ARGS*DATA_W-1:0] args);
    f_wdata = '0;
    for (int i = 0; i < NUM_ARGS; i++)
      if (idx == IW'(i)) f_wdata = args[i*DATA_W +: DATA_W];
  endfunction

  assign w_run     = (r_state == S_RUN);
  assign w_start   = start & ~abort & ((r_state == S_IDLE) | (r_state == S_FINISH));
  assign w_node_wr = w_run & ~abort & cpu_we & (cpu_addr == NODE_ADDR);
  assign w_done_wr = w_run & cpu_we & (cpu_addr == DONE_ADDR) & (cpu_wdata == DATA_W'(1));
  assign w_tmo     = (TIMEOUT_CYC != 0) & w_run & (r_timer == TO_LAST);
  assign w_full    = (r_count == CW'(PATH_DEPTH));
  // A start clears the FIFO, so a pop in that cycle has nothing to act on.
  assign w_pop     = path_rd & (r_count != '0) & ~w_start;
  // Full + pop in the same cycle frees a slot, so the push is accepted.
  assign w_push    = w_node_wr & (~w_full | w_pop);

  assign busy       = (r_state == S_LOAD) | (r_state == S_RUN);
  assign path_data  = r_mem[r_rp];
  assign path_empty = (r_count == '0);
  assign path_count = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_timer   <= '0;
      r_args    <= '0;
      cpu_reset <= 1'b1;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      path_ovf  <= 1'b0;
      last_node <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else if (abort) begin
      // Flags, FIFO contents and last_node survive an abort.
      r_state   <= S_IDLE;
      cpu_reset <= 1'b1;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: begin
          cpu_reset <= 1'b1;
          if (start) begin
            r_state   <= S_LOAD;
            r_args    <= args_in;
            r_idx     <= '0;
            // First write is presented in the first LOAD cycle.
            ext_we    <= 1'b1;
            ext_addr  <= BASE_ADDR;
            ext_wdata <= f_wdata('0, args_in);
            path_ovf  <= 1'b0;
            last_node <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r_idx == LAST_IDX) begin
            r_state   <= S_RUN;
            r_timer   <= '0;
            cpu_reset <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
          end else begin
            r_idx     <= r_idx + IW'(1);
            ext_addr  <= BASE_ADDR + (32'(r_idx + IW'(1)) << 2);
            ext_wdata <= f_wdata(r_idx + IW'(1), r_args);
          end
        end
        S_RUN: begin
          r_timer <= r_timer + 32'd1;
          if (w_node_wr) begin
            last_node <= cpu_wdata;
            if (w_full && !w_pop) path_ovf <= 1'b1;
          end
          // DONE outranks a coincident timeout.
          if (w_done_wr) begin
            done      <= 1'b1;
            cpu_reset <= 1'b1;
            r_state   <= S_FINISH;
          end else if (w_tmo) begin
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
            r_state   <= S_FINISH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= cpu_wdata;
  end

endmodule

// File: tb/tb_cpu_mailbox_ctrl.sv
// Directed bench for cpu_mailbox_ctrl with a 4-deep path FIFO and a
// 100-cycle run timeout. Inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_cpu_mailbox_ctrl;

  localparam int DW = 32;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] NODE = 32'h0200_0008;
  localparam logic [31:0] DONE = 32'h0200_000C;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, abort;
  logic [2*DW-1:0] args_in;
  logic            cpu_reset, ext_we;
  logic [31:0]     ext_addr;
  logic [DW-1:0]   ext_wdata;
  logic            cpu_we;
  logic [31:0]     cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            path_rd;
  logic [DW-1:0]   path_data;
  logic            path_empty;
  logic [2:0]      path_count;
  logic            path_ovf;
  logic [DW-1:0]   last_node;
  logic            busy, done, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_mailbox_ctrl #(
    .DATA_W(DW), .BASE_ADDR(BASE), .NUM_ARGS(2), .PATH_DEPTH(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .args_in(args_in),
    .cpu_reset(cpu_reset), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .path_rd(path_rd), .path_data(path_data), .path_empty(path_empty),
    .path_count(path_count), .path_ovf(path_ovf), .last_node(last_node),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [DW-1:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic do_start(input logic [2*DW-1:0] a);
    args_in = a; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for cpu_reset to drop (RUN entry); bounded.
  task automatic wait_run();
    int k;
    for (k = 0; k < 10 && cpu_reset !== 1'b0; k++) tick();
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_bad++; $display("FAIL wait_run: cpu_reset=%b required 0 within 10 cycles", cpu_reset);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; abort = 0; args_in = '0;
    cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; path_rd = 0;
    tick(); tick();
    n_cmp++;
    if ({cpu_reset, ext_we, ext_addr, ext_wdata} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL reset_ext: cpu_reset=%b we=%b addr=%h data=%h required 1 0 0 0",
                        cpu_reset, ext_we, ext_addr, ext_wdata);
    end
    n_cmp++;
    if ({path_empty, path_count, path_ovf, busy, done, timeout, last_node} !==
        {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      n_bad++; $display("FAIL reset_status: empty=%b cnt=%0d ovf=%b busy=%b done=%b to=%b last=%0d",
                        path_empty, path_count, path_ovf, busy, done, timeout, last_node);
    end
    reset_n = 1'b1;
    tick();
  endtask

  // T1: four consecutive mailbox writes, then CPU released.
  task automatic test_load();
    logic [31:0] exp_a [4] = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008, 32'h0200_000C};
    logic [31:0] exp_d [4] = '{32'd29, 32'd18, 32'd0, 32'd0};
    do_start({32'd18, 32'd29});
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ext_we, ext_addr, ext_wdata, cpu_reset, busy} !== {1'b1, exp_a[i], exp_d[i], 1'b1, 1'b1}) begin
        n_bad++; $display("FAIL load_w%0d: we=%b addr=%h data=%0d rst=%b busy=%b required 1 %h %0d 1 1",
                          i, ext_we, ext_addr, ext_wdata, cpu_reset, busy, exp_a[i], exp_d[i]);
      end
      tick();
    end
    n_cmp++;
    if ({ext_we, ext_addr, ext_wdata, cpu_reset, busy} !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL load_end: we=%b addr=%h data=%h rst=%b busy=%b required 0 0 0 0 1",
                        ext_we, ext_addr, ext_wdata, cpu_reset, busy);
    end
  endtask

  // T2: three node writes, DONE, then drain.
  task automatic test_path();
    logic [31:0] v [3] = '{32'd5, 32'd7, 32'd18};
    cpu_write(NODE, v[0]);
    n_cmp++;
    if (last_node !== 32'd5) begin
      n_bad++; $display("FAIL last_node_1: got %0d required 5", last_node);
    end
    cpu_write(32'h0200_0010, 32'd99);  // unrelated address, ignored
    cpu_write(NODE, v[1]);
    cpu_write(NODE, v[2]);
    cpu_write(DONE, 32'd1);
    n_cmp++;
    if ({path_count, done, timeout, cpu_reset, busy, last_node} !== {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'd18}) begin
      n_bad++; $display("FAIL path_done: cnt=%0d done=%b to=%b rst=%b busy=%b last=%0d required 3 1 0 1 0 18",
                        path_count, done, timeout, cpu_reset, busy, last_node);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (path_data !== v[i]) begin
        n_bad++; $display("FAIL path_pop%0d: got %0d required %0d", i, path_data, v[i]);
      end
      path_rd = 1'b1; tick(); path_rd = 1'b0;
    end
    path_rd = 1'b1; tick(); path_rd = 1'b0;  // pop on empty
    n_cmp++;
    if ({path_empty, path_count} !== {1'b1, 3'd0}) begin
      n_bad++; $display("FAIL path_empty: empty=%b cnt=%0d required 1 0", path_empty, path_count);
    end
  endtask

  // T3: six node writes into a 4-deep FIFO.
  task automatic test_overflow();
    do_start({32'd2, 32'd1});
    n_cmp++;
    if ({done, busy} !== {1'b0, 1'b1}) begin
      n_bad++; $display("FAIL restart_clear: done=%b busy=%b required 0 1", done, busy);
    end
    wait_run();
    for (int i = 0; i < 6; i++) cpu_write(NODE, 32'(10 + i));
    n_cmp++;
    if ({path_count, path_ovf, last_node} !== {3'd4, 1'b1, 32'd15}) begin
      n_bad++; $display("FAIL ovf: cnt=%0d ovf=%b last=%0d required 4 1 15", path_count, path_ovf, last_node);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (path_data !== 32'(10 + i)) begin
        n_bad++; $display("FAIL ovf_pop%0d: got %0d required %0d", i, path_data, 10 + i);
      end
      path_rd = 1'b1; tick(); path_rd = 1'b0;
    end
  endtask

  // Abort keeps flags; abort beats a simultaneous start.
  task automatic test_abort();
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if ({busy, cpu_reset, ext_we, path_ovf, last_node} !== {1'b0, 1'b1, 1'b0, 1'b1, 32'd15}) begin
      n_bad++; $display("FAIL abort: busy=%b rst=%b we=%b ovf=%b last=%0d required 0 1 0 1 15",
                        busy, cpu_reset, ext_we, path_ovf, last_node);
    end
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, ext_we, path_ovf} !== {1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL abort_start: busy=%b we=%b ovf=%b required 0 0 1", busy, ext_we, path_ovf);
    end
  endtask

  // T6: full FIFO, pop and push in the same cycle.
  task automatic test_back_to_back();
    logic [31:0] e [4] = '{32'd21, 32'd22, 32'd23, 32'd24};
    do_start({32'd2, 32'd1});
    wait_run();
    for (int i = 0; i < 4; i++) cpu_write(NODE, 32'(20 + i));
    path_rd = 1'b1;
    cpu_write(NODE, 32'd24);
    path_rd = 1'b0;
    n_cmp++;
    if ({path_count, path_ovf} !== {3'd4, 1'b0}) begin
      n_bad++; $display("FAIL b2b_count: cnt=%0d ovf=%b required 4 0", path_count, path_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (path_data !== e[i]) begin
        n_bad++; $display("FAIL b2b_pop%0d: got %0d required %0d", i, path_data, e[i]);
      end
      path_rd = 1'b1; tick(); path_rd = 1'b0;
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // T4: timeout exactly 100 cycles after RUN entry.
  task automatic test_timeout();
    do_start({32'd2, 32'd1});
    wait_run();
    for (int i = 0; i < 99; i++) tick();
    n_cmp++;
    if ({timeout, busy} !== {1'b0, 1'b1}) begin
      n_bad++; $display("FAIL timeout_early: to=%b busy=%b required 0 1", timeout, busy);
    end
    tick();
    n_cmp++;
    if ({timeout, done, cpu_reset, busy} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL timeout: to=%b done=%b rst=%b busy=%b required 1 0 1 0",
                        timeout, done, cpu_reset, busy);
    end
  endtask

  // DONE of a wrong value is ignored; DONE in the timeout cycle wins.
  task automatic test_done_vs_timeout();
    do_start({32'd2, 32'd1});
    wait_run();
    cpu_write(DONE, 32'd2);
    n_cmp++;
    if ({done, busy} !== {1'b0, 1'b1}) begin
      n_bad++; $display("FAIL done_val2: done=%b busy=%b required 0 1", done, busy);
    end
    for (int i = 0; i < 98; i++) tick();
    cpu_write(DONE, 32'd1);
    n_cmp++;
    if ({done, timeout, busy} !== {1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL done_wins: done=%b to=%b busy=%b required 1 0 0", done, timeout, busy);
    end
  endtask

  // T5: async reset mid-LOAD, then a clean rerun from idx 0.
  task automatic test_reset_mid_load();
    do_start({32'd7, 32'd3});
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ext_we, ext_addr, cpu_reset, busy, done, path_count} !== {1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_bad++; $display("FAIL mid_reset: we=%b addr=%h rst=%b busy=%b done=%b cnt=%0d required 0 0 1 0 0 0",
                        ext_we, ext_addr, cpu_reset, busy, done, path_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
    do_start({32'd7, 32'd3});
    n_cmp++;
    if ({ext_we, ext_addr, ext_wdata} !== {1'b1, BASE, 32'd3}) begin
      n_bad++; $display("FAIL rerun_w0: we=%b addr=%h data=%0d required 1 %h 3", ext_we, ext_addr, ext_wdata, BASE);
    end
    tick();
    n_cmp++;
    if ({ext_we, ext_addr, ext_wdata} !== {1'b1, 32'h0200_0004, 32'd7}) begin
      n_bad++; $display("FAIL rerun_w1: we=%b addr=%h data=%0d required 1 02000004 7", ext_we, ext_addr, ext_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_path();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
